// File: rtl/serial_add_sub_4_bit.sv
// serial_add_sub_4_bit: 4-bit two's complement add/subtract computed one bit
// per cycle, LSB first, through a single full adder and one carry flop.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst    : synchronous active-high reset
//   start  : operation request, sampled only while idle
//   M      : mode, 0 = A_in + B_in, 1 = A_in - B_in
//   A_in   : operand A, captured with start
//   B_in   : operand B, captured with start
//   busy   : high while operand bits are being processed
//   done   : one-cycle pulse, S_out/V/C4 valid from this cycle on
//   S_out  : result
//   V      : signed overflow (carry into bit 3 XOR carry out of bit 3)
//   C4     : carry out of bit 3
module serial_add_sub_4_bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       M,
  input  logic [3:0] A_in,
  input  logic [3:0] B_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] S_out,
  output logic       V,
  output logic       C4
);

  localparam int unsigned W  = 4;
  localparam int unsigned IW = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Datapath registers
  logic [W-1:0]  a_q, b_q, acc_q;
  logic          carry_q;
  logic [IW-1:0] idx_q;

  // Next values for every datapath register and output
  logic [W-1:0]  a_d, b_d, acc_d, s_d;
  logic          carry_d, busy_d, done_d, v_d, c4_d;
  logic [IW-1:0] idx_d;

  // The single full adder
  logic fa_a, fa_b, fa_s, fa_co, last_bit;

  assign fa_a     = a_q[idx_q];
  assign fa_b     = b_q[idx_q];
  assign fa_s     = fa_a ^ fa_b ^ carry_q;
  assign fa_co    = (fa_a & fa_b) | (fa_a & carry_q) | (fa_b & carry_q);
  assign last_bit = (idx_q == IW'(W - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; leaving RUN after bit 3 keeps the index from wrapping
  // into a fifth step
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath / output next values
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    s_d     = S_out;
    v_d     = V;
    c4_d    = C4;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          // Subtraction: invert B here and inject M as the initial carry
          a_d     = A_in;
          b_d     = B_in ^ {W{M}};
          carry_d = M;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        acc_d[idx_q] = fa_s;
        carry_d      = fa_co;
        idx_d        = idx_q + IW'(1);
        if (last_bit) begin
          // carry_q is the carry into bit 3, fa_co the carry out of it
          s_d    = acc_d;
          c4_d   = fa_co;
          v_d    = carry_q ^ fa_co;
          done_d = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      S_out   <= '0;
      V       <= 1'b0;
      C4      <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      busy    <= busy_d;
      done    <= done_d;
      S_out   <= s_d;
      V       <= v_d;
      C4      <= c4_d;
    end
  end

endmodule

// File: tb/tb_serial_add_sub_4_bit.sv
// Self-checking bench for serial_add_sub_4_bit: directed vector table,
// hand-written corner sequences, exhaustive sweep and random operations
// compared against a signed/unsigned arithmetic reference model.
module tb_serial_add_sub_4_bit;

  logic       clk = 1'b0;
  logic       rst, start, M;
  logic [3:0] A_in, B_in;
  logic       busy, done, V, C4;
  logic [3:0] S_out;

  int tests = 0;
  int fails = 0;

  serial_add_sub_4_bit dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .M    (M),
    .A_in (A_in),
    .B_in (B_in),
    .busy (busy),
    .done (done),
    .S_out(S_out),
    .V    (V),
    .C4   (C4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
    logic       c4;
    logic       v;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: signed result range decides V, unsigned carry/borrow decides C4
  function automatic void model(input logic m, input logic [3:0] a, input logic [3:0] b,
                                output logic [3:0] s, output logic c4, output logic v);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = m ? (sa - sb) : (sa + sb);
    s  = 4'(r);
    v  = (r > 7) || (r < -8);
    c4 = m ? (a >= b) : ((int'(a) + int'(b)) > 15);
  endfunction

  // One operation: start on the next edge, then scramble inputs and wait for done
  task automatic do_op(input logic m, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] es, input logic ec, input logic ev, input string tag);
    int n, nbusy;
    @(negedge clk);
    start = 1'b1; M = m; A_in = a; B_in = b;
    @(posedge clk); #1;
    start = 1'b0;
    M     = 1'($urandom);
    A_in  = 4'($urandom);
    B_in  = 4'($urandom);
    check({tag, " busy after start edge"}, 32'(busy), 32'd0);
    n = 0; nbusy = 0;
    while (!done && n < 8) begin
      @(posedge clk); #1;
      n++;
      if (busy) nbusy++;
    end
    check({tag, " done latency"}, 32'(n), 32'd4);
    check({tag, " busy cycles"}, 32'(nbusy), 32'd3);
    check({tag, " S_out"}, 32'(S_out), 32'(es));
    check({tag, " C4"}, 32'(C4), 32'(ec));
    check({tag, " V"}, 32'(V), 32'(ev));
  endtask

  task automatic model_op(input logic m, input logic [3:0] a, input logic [3:0] b, input string tag);
    logic [3:0] es;
    logic       ec, ev;
    model(m, a, b, es, ec, ev);
    do_op(m, a, b, es, ec, ev, tag);
  endtask

  initial begin
    int n, nd;

    //          m     a        b        s        c4    v
    vecs[0] = '{1'b0, 4'b0011, 4'b0101, 4'b1000, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 4'b0111, 4'b0010, 4'b0101, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 4'b0000, 4'b0001, 4'b1111, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1};

    rst = 1'b1; start = 1'b0; M = 1'b0; A_in = '0; B_in = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset S_out", 32'(S_out), 32'd0);
    check("reset V", 32'(V), 32'd0);
    check("reset C4", 32'(C4), 32'd0);

    // Released here so the first table entry starts on the first edge with rst=0;
    // entries are issued back to back, each start landing in the previous done cycle
    rst = 1'b0;
    for (int i = 0; i < 8; i++)
      do_op(vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c4, vecs[i].v,
            $sformatf("vec%0d", i));

    // start while running is ignored
    @(negedge clk);
    start = 1'b1; M = 1'b0; A_in = 4'b0001; B_in = 4'b0001;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; A_in = 4'b1111;
    @(posedge clk); #1;
    start = 1'b0;
    n = 2;
    while (!done && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("ignore-start latency", 32'(n), 32'd4);
    check("ignore-start S_out", 32'(S_out), 32'b0010);
    check("ignore-start C4", 32'(C4), 32'd0);
    check("ignore-start V", 32'(V), 32'd0);
    nd = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("ignore-start extra done", 32'(nd), 32'd0);

    // Reset two cycles into RUN aborts the operation
    @(negedge clk);
    start = 1'b1; M = 1'b0; A_in = 4'd7; B_in = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort S_out", 32'(S_out), 32'd0);
    check("abort V", 32'(V), 32'd0);
    check("abort C4", 32'(C4), 32'd0);
    rst = 1'b0;
    nd = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("abort no done", 32'(nd), 32'd0);
    model_op(1'b0, 4'd6, 4'd5, "after-abort");

    // Exhaustive sweep, back to back
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          model_op(1'(m), 4'(a), 4'(b), $sformatf("sweep m%0d a%0d b%0d", m, a, b));

    // Random operations with random idle gaps
    repeat (200) begin
      logic       rm;
      logic [3:0] ra, rb;
      rm = 1'($urandom);
      ra = 4'($urandom);
      rb = 4'($urandom);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      model_op(rm, ra, rb, $sformatf("rand m%0d a%0d b%0d", rm, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
